// File: rtl/exe_stage.sv
// Execute stage: latches one decoded instruction from ID, produces the ALU or divider result and the data-SRAM request.
// Non-divide instructions spend one cycle here; divides take 33 cycles from capture until es_to_ms_valid rises.
// ms_allow_in low freezes the stage, including a finished divide held in DONE; es_allow_in drops while the stage is occupied and blocked.
module exe_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  // ID side
  input  logic        ds_to_es_valid,
  output logic        es_allow_in,
  input  logic [31:0] ds_pc,
  input  logic [11:0] ds_alu_op,
  input  logic [3:0]  ds_div_op,
  input  logic [31:0] ds_src1,
  input  logic [31:0] ds_src2,
  input  logic [31:0] ds_store_data,
  input  logic        ds_mem_re,
  input  logic        ds_mem_we,
  input  logic        ds_ld_b,
  input  logic        ds_st_b,
  input  logic [3:0]  ds_rf_we,
  input  logic [4:0]  ds_rf_waddr,
  // MEM side
  input  logic        ms_allow_in,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic [3:0]  es_rf_we,
  output logic [4:0]  es_rf_waddr,
  // data SRAM request
  output logic        es_sram_en,
  output logic [3:0]  es_sram_we,
  output logic [31:0] es_sram_addr,
  output logic [31:0] es_sram_wdata,
  output logic        es_ld_b,
  // hazard / status
  output logic        es_is_load,
  output logic        es_div_busy
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // ------------------------------------------------------------------
  // Input register
  // ------------------------------------------------------------------
  logic        es_valid_q;
  logic [31:0] pc_q;
  logic [11:0] alu_op_q;
  logic [3:0]  div_op_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [31:0] store_data_q;
  logic        mem_re_q;
  logic        mem_we_q;
  logic        ld_b_q;
  logic        st_b_q;
  logic [3:0]  rf_we_q;
  logic [4:0]  rf_waddr_q;

  logic        es_ready_go;

  // Capture a new instruction from ID whenever this stage has room for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q   <= 1'b0;
      pc_q         <= RESET_PC;
      alu_op_q     <= '0;
      div_op_q     <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      store_data_q <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      ld_b_q       <= 1'b0;
      st_b_q       <= 1'b0;
      rf_we_q      <= '0;
      rf_waddr_q   <= '0;
    end else begin
      if (es_allow_in) begin
        es_valid_q <= ds_to_es_valid;
      end
      if (es_allow_in && ds_to_es_valid) begin
        pc_q         <= ds_pc;
        alu_op_q     <= ds_alu_op;
        div_op_q     <= ds_div_op;
        src1_q       <= ds_src1;
        src2_q       <= ds_src2;
        store_data_q <= ds_store_data;
        mem_re_q     <= ds_mem_re;
        mem_we_q     <= ds_mem_we;
        ld_b_q       <= ds_ld_b;
        st_b_q       <= ds_st_b;
        rf_we_q      <= ds_rf_we;
        rf_waddr_q   <= ds_rf_waddr;
      end
    end
  end

  // ------------------------------------------------------------------
  // ALU
  // ------------------------------------------------------------------
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sra_res;
  logic [31:0] alu_result;

  assign add_res  = src1_q + src2_q;
  assign sub_res  = src1_q - src2_q;
  assign slt_res  = {31'd0, ($signed(src1_q) < $signed(src2_q))};
  assign sltu_res = {31'd0, (src1_q < src2_q)};
  assign sra_res  = $unsigned($signed(src1_q) >>> src2_q[4:0]);

  // One-hot AND-OR select; an all-zero op yields zero.
  always_comb begin
    alu_result = '0;
    alu_result = ({32{alu_op_q[0]}}  & add_res)
               | ({32{alu_op_q[1]}}  & sub_res)
               | ({32{alu_op_q[2]}}  & slt_res)
               | ({32{alu_op_q[3]}}  & sltu_res)
               | ({32{alu_op_q[4]}}  & (src1_q & src2_q))
               | ({32{alu_op_q[5]}}  & (src1_q | src2_q))
               | ({32{alu_op_q[6]}}  & ~(src1_q | src2_q))
               | ({32{alu_op_q[7]}}  & (src1_q ^ src2_q))
               | ({32{alu_op_q[8]}}  & (src1_q << src2_q[4:0]))
               | ({32{alu_op_q[9]}}  & (src1_q >> src2_q[4:0]))
               | ({32{alu_op_q[10]}} & sra_res)
               | ({32{alu_op_q[11]}} & src2_q);
  end

  // ------------------------------------------------------------------
  // Divider: radix-2 restoring on magnitudes, sign fix-up applied on the way out
  // ------------------------------------------------------------------
  div_state_t  div_state_q, div_state_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [31:0] div_a_q, div_a_d;      // dividend magnitude, shifted out MSB first
  logic [31:0] div_b_q, div_b_d;      // divisor magnitude
  logic [31:0] div_rem_q, div_rem_d;  // partial remainder, always < divisor once nonzero
  logic [31:0] div_quo_q, div_quo_d;
  logic        div_qneg_q, div_qneg_d;
  logic        div_rneg_q, div_rneg_d;

  logic        div_signed;
  logic        div_start;
  logic [31:0] div_abs1;
  logic [31:0] div_abs2;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  assign div_signed = div_op_q[0] | div_op_q[1];
  assign div_start  = es_valid_q && (div_op_q != 4'd0);
  assign div_abs1   = (div_signed && src1_q[31]) ? (32'd0 - src1_q) : src1_q;
  assign div_abs2   = (div_signed && src2_q[31]) ? (32'd0 - src2_q) : src2_q;

  // Borrow out of the 33-bit subtraction means the trial remainder is below the divisor.
  assign div_trial  = {div_rem_q, div_a_q[31]};
  assign div_diff   = div_trial - {1'b0, div_b_q};

  // A zero divisor never borrows, so the quotient fills with ones and the remainder collects the dividend.
  assign div_quotient  = div_qneg_q ? (32'd0 - div_quo_q) : div_quo_q;
  assign div_remainder = div_rneg_q ? (32'd0 - div_rem_q) : div_rem_q;

  // Divider next-state: start on a valid divide, 32 iterations, then hold until MEM takes it.
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    div_rem_d   = div_rem_q;
    div_quo_d   = div_quo_q;
    div_qneg_d  = div_qneg_q;
    div_rneg_d  = div_rneg_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (div_start) begin
          div_state_d = DIV_BUSY;
          div_cnt_d   = 5'd0;
          div_a_d     = div_abs1;
          div_b_d     = div_abs2;
          div_rem_d   = 32'd0;
          div_quo_d   = 32'd0;
          div_qneg_d  = div_signed && (src1_q[31] ^ src2_q[31]);
          div_rneg_d  = div_signed && src1_q[31];
        end
      end
      DIV_BUSY: begin
        div_a_d   = {div_a_q[30:0], 1'b0};
        div_cnt_d = div_cnt_q + 5'd1;
        if (!div_diff[32]) begin
          div_rem_d = div_diff[31:0];
          div_quo_d = {div_quo_q[30:0], 1'b1};
        end else begin
          div_rem_d = div_trial[31:0];
          div_quo_d = {div_quo_q[30:0], 1'b0};
        end
        if (div_cnt_q == 5'd31) begin
          div_state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (es_ready_go && ms_allow_in) begin
          div_state_d = DIV_IDLE;
        end
      end
      default: begin
        div_state_d = DIV_IDLE;
      end
    endcase
  end

  // Divider state register; reset abandons any divide in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_qneg_q  <= 1'b0;
      div_rneg_q  <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_qneg_q  <= div_qneg_d;
      div_rneg_q  <= div_rneg_d;
    end
  end

  // ------------------------------------------------------------------
  // Handshake and result select
  // ------------------------------------------------------------------
  assign es_ready_go    = (div_op_q == 4'd0) || (div_state_q == DIV_DONE);
  assign es_allow_in    = !es_valid_q || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign es_div_busy    = (div_state_q != DIV_IDLE);

  // div.w/div.wu take the quotient, mod.w/mod.wu the remainder, everything else the ALU.
  always_comb begin
    es_result = alu_result;
    if (div_op_q[0] || div_op_q[2]) begin
      es_result = div_quotient;
    end else if (div_op_q[1] || div_op_q[3]) begin
      es_result = div_remainder;
    end
  end

  // ------------------------------------------------------------------
  // Data-SRAM request
  // ------------------------------------------------------------------
  logic [3:0] st_b_mask;

  // Byte store lane follows the low address bits.
  always_comb begin
    st_b_mask = 4'b0001;
    case (add_res[1:0])
      2'd0: st_b_mask = 4'b0001;
      2'd1: st_b_mask = 4'b0010;
      2'd2: st_b_mask = 4'b0100;
      2'd3: st_b_mask = 4'b1000;
      default: st_b_mask = 4'b0001;
    endcase
  end

  assign es_sram_en    = es_valid_q && (mem_re_q || mem_we_q);
  assign es_sram_we    = (es_valid_q && mem_we_q) ? (st_b_q ? st_b_mask : 4'hF) : 4'h0;
  assign es_sram_addr  = add_res;
  assign es_sram_wdata = st_b_q ? {4{store_data_q[7:0]}} : store_data_q;
  assign es_ld_b       = ld_b_q;

  assign es_pc         = pc_q;
  assign es_rf_we      = es_valid_q ? rf_we_q : 4'h0;
  assign es_rf_waddr   = rf_waddr_q;
  assign es_is_load    = es_valid_q && mem_re_q;

endmodule
